// File: rtl/tpu_sequencer_if.sv
// Start/result and weight-ROM bus of the two-layer inference sequencer.
// The master drives the start request, the image and the ROM data; the slave is the sequencer.
interface tpu_sequencer_if #(
  parameter int IN_N = 1024
);
  logic            ena;
  logic [IN_N-1:0] input_image;
  logic [15:0]     w_addr;
  logic [7:0]      w_data;
  logic            busy;
  logic [3:0]      num_out;
  logic            done;

  modport master (
    output ena, input_image, w_data,
    input  w_addr, busy, num_out, done
  );

  modport slave (
    input  ena, input_image, w_data,
    output w_addr, busy, num_out, done
  );
endinterface

// File: rtl/tpu_sequencer.sv
// Binary-image two-layer MLP sequencer: streams signed weights from an external ROM,
// applies a saturating ReLU to the hidden layer and reports the output argmax.
module tpu_sequencer #(
  parameter int IN_N  = 1024,
  parameter int HID_N = 32,
  parameter int OUT_N = 10
) (
  input logic           clk,
  input logic           iRst_n,
  tpu_sequencer_if.slave bus
);
  localparam int PW = $clog2(IN_N);
  localparam int HW = $clog2(HID_N);
  localparam int CW = (PW > HW) ? PW : HW;

  typedef enum logic [2:0] {IDLE, L1_RUN, L1_WB, L2_RUN, L2_WB, DONE} state_t;

  state_t                state_reg, state_next;
  logic [IN_N-1:0]       image_reg;
  logic [15:0]           h_reg [HID_N];
  logic [CW-1:0]         i_reg;
  logic [HW-1:0]         j_reg;
  logic [3:0]            k_reg;
  logic signed [31:0]    acc_reg, best_reg;
  logic [3:0]            best_idx_reg;
  logic                  acc_en_reg, pix_reg, publish_reg;
  logic [15:0]           h_sel_reg;
  logic [15:0]           w_addr_reg;
  logic                  done_reg;
  logic [3:0]            num_reg;

  logic                  layer1, last_i, last_j, last_k;
  logic signed [24:0]    prod;
  logic signed [31:0]    term, sum;
  logic [15:0]           h_new;

  assign layer1 = (state_reg == L1_RUN) || (state_reg == L1_WB);
  assign last_i = layer1 ? (i_reg == CW'(IN_N - 1)) : (i_reg == CW'(HID_N - 1));
  assign last_j = (j_reg == HW'(HID_N - 1));
  assign last_k = (k_reg == 4'(OUT_N - 1));

  // Data returns one cycle after its address, so the term added now belongs to last cycle's address.
  assign prod = $signed({{17{bus.w_data[7]}}, bus.w_data}) * $signed({9'b0, h_sel_reg});

  always_comb begin
    term = '0;
    if (acc_en_reg) begin
      if (layer1) term = pix_reg ? {{24{bus.w_data[7]}}, bus.w_data} : 32'sd0;
      else        term = {{7{prod[24]}}, prod};
    end
  end

  assign sum = acc_reg + term;

  always_comb begin
    h_new = sum[15:0];
    if (sum[31])              h_new = '0;
    else if (sum > 32'sd65535) h_new = 16'hFFFF;
  end

  always_ff @(posedge clk) begin
    if (!iRst_n) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (bus.ena) state_next = L1_RUN;
      L1_RUN:  if (last_i)  state_next = L1_WB;
      L1_WB:   state_next = last_j ? L2_RUN : L1_RUN;
      L2_RUN:  if (last_i)  state_next = L2_WB;
      L2_WB:   state_next = last_k ? DONE : L2_RUN;
      DONE:    if (!bus.ena) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      image_reg    <= '0;
      i_reg        <= '0;
      j_reg        <= '0;
      k_reg        <= '0;
      acc_reg      <= '0;
      best_reg     <= '0;
      best_idx_reg <= '0;
      acc_en_reg   <= 1'b0;
      pix_reg      <= 1'b0;
      publish_reg  <= 1'b0;
      h_sel_reg    <= '0;
      w_addr_reg   <= '0;
      done_reg     <= 1'b0;
      num_reg      <= '0;
      for (int n = 0; n < HID_N; n++) h_reg[n] <= '0;
    end else begin
      publish_reg <= 1'b0;
      if (publish_reg) begin
        done_reg <= 1'b1;
        num_reg  <= best_idx_reg;
      end
      unique case (state_reg)
        IDLE: if (bus.ena) begin
          image_reg  <= bus.input_image;
          done_reg   <= 1'b0;
          num_reg    <= '0;
          acc_reg    <= '0;
          acc_en_reg <= 1'b0;
          i_reg      <= '0;
          j_reg      <= '0;
          k_reg      <= '0;
          w_addr_reg <= '0;
        end
        L1_RUN, L2_RUN: begin
          acc_reg    <= sum;
          acc_en_reg <= 1'b1;
          pix_reg    <= image_reg[i_reg[PW-1:0]];
          h_sel_reg  <= h_reg[i_reg[HW-1:0]];
          if (!last_i) begin
            i_reg      <= i_reg + CW'(1);
            w_addr_reg <= w_addr_reg + 16'd1;
          end
        end
        L1_WB: begin
          h_reg[j_reg] <= h_new;
          acc_reg      <= '0;
          acc_en_reg   <= 1'b0;
          i_reg        <= '0;
          j_reg        <= last_j ? '0 : j_reg + HW'(1);
          w_addr_reg   <= w_addr_reg + 16'd1;
        end
        L2_WB: begin
          // Strictly-greater replacement keeps the lowest index on ties.
          if (k_reg == 4'd0 || sum > best_reg) begin
            best_reg     <= sum;
            best_idx_reg <= k_reg;
          end
          acc_reg    <= '0;
          acc_en_reg <= 1'b0;
          i_reg      <= '0;
          if (last_k) publish_reg <= 1'b1;
          else begin
            k_reg      <= k_reg + 4'd1;
            w_addr_reg <= w_addr_reg + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_reg == L1_RUN) || (state_reg == L1_WB) ||
                       (state_reg == L2_RUN) || (state_reg == L2_WB);
  assign bus.w_addr  = w_addr_reg;
  assign bus.done    = done_reg;
  assign bus.num_out = num_reg;
endmodule

// File: tb/tb_tpu_sequencer.sv
// Bench for tpu_sequencer: directed runs against a whole-network reference model,
// with a per-cycle check of busy/done/num_out/w_addr timing.
module tb_tpu_sequencer;
  localparam int IN_N  = 520;
  localparam int HID_N = 4;
  localparam int OUT_N = 10;
  localparam int L1C   = HID_N * (IN_N + 1);
  localparam int XC    = L1C + OUT_N * (HID_N + 1);
  localparam int LAT   = 1 + XC;
  localparam int L2B   = HID_N * IN_N;
  localparam int ROM_N = L2B + OUT_N * HID_N;

  logic clk = 1'b0;
  logic iRst_n;
  always #5 clk = ~clk;

  tpu_sequencer_if #(.IN_N(IN_N)) bus ();

  tpu_sequencer #(.IN_N(IN_N), .HID_N(HID_N), .OUT_N(OUT_N)) dut (
    .clk(clk), .iRst_n(iRst_n), .bus(bus)
  );

  logic signed [7:0] rom [ROM_N];
  logic [IN_N-1:0]   img;
  always @(posedge clk) bus.w_data <= rom[bus.w_addr];

  int       compared = 0;
  int       mismatched = 0;
  int       n = 0;
  bit       tracking = 1'b0;
  logic [3:0] exp_num = '0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  // Whole-network reference: ReLU saturated to 16 bits, then lowest-index argmax.
  function automatic logic [3:0] model_argmax();
    longint h [HID_N];
    longint s, best;
    int     bi;
    for (int j = 0; j < HID_N; j++) begin
      s = 0;
      for (int i = 0; i < IN_N; i++) if (img[i]) s += longint'(rom[j*IN_N + i]);
      h[j] = (s < 0) ? 0 : ((s > 65535) ? 65535 : s);
    end
    best = 0; bi = 0;
    for (int k = 0; k < OUT_N; k++) begin
      s = 0;
      for (int j = 0; j < HID_N; j++) s += longint'(rom[L2B + k*HID_N + j]) * h[j];
      if (k == 0 || s > best) begin best = s; bi = k; end
    end
    return 4'(bi);
  endfunction

  // Expected {busy, done, num_out, w_addr} n cycles after the start edge.
  function automatic logic [21:0] expect_at(int c);
    int q, p, m;
    logic [15:0] a;
    logic b, d;
    if (c < L1C) begin
      q = c / (IN_N + 1); p = c % (IN_N + 1);
      a = 16'(q*IN_N + ((p < IN_N) ? p : IN_N - 1));
    end else if (c < XC) begin
      m = c - L1C; q = m / (HID_N + 1); p = m % (HID_N + 1);
      a = 16'(L2B + q*HID_N + ((p < HID_N) ? p : HID_N - 1));
    end else a = 16'(ROM_N - 1);
    b = (c < XC);
    d = (c >= XC + 1);
    return {b, d, (d ? exp_num : 4'd0), a};
  endfunction

  always @(negedge clk) begin
    if (tracking) begin
      logic [21:0] got, exp;
      got = {bus.busy, bus.done, bus.num_out, bus.w_addr};
      exp = expect_at(n);
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL cycle_check n=%0d: got busy=%b done=%b num=%0d addr=%0d expected busy=%b done=%b num=%0d addr=%0d",
                 n, got[21], got[20], got[19:16], got[15:0], exp[21], exp[20], exp[19:16], exp[15:0]);
      end
      n++;
    end
  end

  task automatic fill_rom(input int mode);
    for (int a = 0; a < ROM_N; a++) begin
      if (mode == 1) rom[a] = 8'($urandom_range(0, 255));
      else if (a < L2B) rom[a] = (mode == 0) ? 8'sd1 : 8'sd127;
      else if (mode == 0) rom[a] = (((a - L2B) / HID_N) == 7) ? 8'sd2 : 8'sd1;
      else rom[a] = (((a - L2B) / HID_N) == 5) ? 8'sd1 : -8'sd1;
    end
  endtask

  task automatic run_case(input string name, input int drop_at, input int abort_at,
                          input int hold, output int done_cyc, output logic [3:0] got_num);
    int  c;
    bit  aborted;
    @(negedge clk);
    bus.input_image = img;
    exp_num = model_argmax();
    bus.ena = 1'b1;
    @(posedge clk);
    n = 0;
    tracking = 1'b1;
    #1 bus.input_image = ~img;
    done_cyc = -1; c = 0; aborted = 1'b0;
    while (1) begin
      @(negedge clk);
      if (abort_at >= 0 && c == abort_at) begin
        tracking = 1'b0;
        bus.ena = 1'b0;
        iRst_n = 1'b0;
        @(posedge clk);
        #1 iRst_n = 1'b1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_addr", 32'(bus.w_addr), 32'd0);
        for (int w = 0; w < 40; w++) begin
          @(negedge clk);
          if (bus.done || bus.busy) begin
            check("abort_quiet", {30'd0, bus.busy, bus.done}, 32'd0);
            break;
          end
        end
        aborted = 1'b1;
        break;
      end
      if (bus.done && done_cyc < 0) done_cyc = c;
      if (c == drop_at) bus.ena = 1'b0;
      if (done_cyc >= 0 && c >= done_cyc + hold) break;
      if (c > LAT + hold + 20) begin
        compared++; mismatched++;
        $display("FAIL %s_timeout: got no done after %0d cycles expected done at %0d", name, c, LAT);
        break;
      end
      c++;
    end
    got_num = bus.num_out;
    if (!aborted) begin
      bus.ena = 1'b0;
      repeat (3) @(negedge clk);
      tracking = 1'b0;
    end
    $display("run %s: done_cycle=%0d num_out=%0d model=%0d aborted=%0d", name, done_cyc, got_num, exp_num, aborted);
  endtask

  initial begin
    int          dc;
    logic [3:0]  num;
    bus.ena = 1'b1;
    bus.input_image = '0;
    img = '0;
    fill_rom(0);
    iRst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_num",  32'(bus.num_out), 32'd0);
    check("reset_addr", 32'(bus.w_addr), 32'd0);
    bus.ena = 1'b0;
    iRst_n = 1'b1;
    repeat (2) @(negedge clk);

    img = '1; fill_rom(0);
    run_case("row7_wins", -1, -1, 5, dc, num);
    check("row7_num", 32'(num), 32'd7);
    check("row7_latency", 32'(dc), 32'd2135);

    img = '0; fill_rom(1);
    run_case("zero_image_tie", -1, -1, 3, dc, num);
    check("zero_image_num", 32'(num), 32'd0);

    img = '1; fill_rom(2);
    run_case("saturate_row5", -1, -1, 3, dc, num);
    check("saturate_num", 32'(num), 32'd5);

    img = '1; fill_rom(0);
    run_case("abort_at_500", -1, 500, 0, dc, num);
    run_case("restart_row7", -1, -1, 3, dc, num);
    check("restart_num", 32'(num), 32'd7);
    check("restart_latency", 32'(dc), 32'd2135);

    for (int i = 0; i < IN_N; i++) img[i] = 1'($urandom_range(0, 1));
    fill_rom(1);
    run_case("ena_drop_at_100", 100, -1, 3, dc, num);
    check("ena_drop_latency", 32'(dc), 32'd2135);

    img = '1; fill_rom(2);
    run_case("ena_held_after_done", -1, -1, 60, dc, num);
    check("held_num", 32'(num), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/tpu_sequencer.md
TPU_SEQUENCER -- requirements
Module: tpu_sequencer

Interface
REQ-001 SHALL provide parameter IN_N, default 1024, meaning input pixels per image.
REQ-002 SHALL provide parameter HID_N, default 32, meaning hidden-layer neurons.
REQ-003 SHALL provide parameter OUT_N, default 10, meaning output classes (at most 16).
REQ-004 SHALL provide port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL provide port iRst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL provide port ena  input  1  level start request, sampled in IDLE.
REQ-007 SHALL provide port input_image  input  IN_N  binary pixels; bit i = pixel i.
REQ-008 SHALL provide port w_addr  output  16  weight ROM address.
REQ-009 SHALL provide port w_data  input  8  signed weight; valid one cycle after w_addr.
REQ-010 SHALL provide port busy  output  1  high in L1_RUN, L1_WB, L2_RUN and L2_WB.
REQ-011 SHALL provide port num_out  output  4  recognised class index.
REQ-012 SHALL provide port done  output  1  result valid.

Function
REQ-013 SHALL implement states IDLE, L1_RUN, L1_WB, L2_RUN, L2_WB, DONE.
REQ-014 IDLE with ena=1 SHALL latch input_image, clear done, num_out, accumulator and counters, then enter L1_RUN.
REQ-015 Weight layout SHALL be: layer 1 weight (j,i) at j*IN_N+i; layer 2 weight (k,j) at HID_N*IN_N+k*HID_N+j.
REQ-016 L1_RUN SHALL issue one address per cycle for i=0..IN_N-1 of neuron j, then enter L1_WB.
REQ-017 Each cycle after an address is issued, the block SHALL add w_data to the 32-bit signed accumulator if the latched pixel is 1; otherwise it SHALL add 0.
REQ-018 L1_WB SHALL accumulate the final weight and store h[j] = 0 if the sum is negative, else min(sum, 65535) as 16-bit unsigned; it SHALL clear the accumulator and take 1 cycle.
REQ-019 After L1_WB, the block SHALL return to L1_RUN for j+1, or go to L2_RUN after j=HID_N-1.
REQ-020 L2_RUN/L2_WB SHALL run the same way over j=0..HID_N-1 for each class k, accumulating signed(w_data)*h[j]; the product SHALL be a full-width 25-bit signed value, sign-extended to 32 bits.
REQ-021 L2_WB SHALL compare the final sum of class k against the running maximum: class 0 always loads it; a later class replaces it only if strictly greater (signed), so a tie keeps the lowest index.
REQ-022 After L2_WB of class OUT_N-1, the block SHALL drive num_out with the argmax index, set done=1 and enter DONE.
REQ-023 Latency: done SHALL rise exactly 1+HID_N*(IN_N+1)+OUT_N*(HID_N+1) cycles after the edge that samples ena in IDLE (33131 for defaults).
REQ-024 ena changes during busy SHALL be ignored; the run SHALL complete.
REQ-025 DONE SHALL hold done=1 and num_out stable while ena=1; ena=0 SHALL return the block to IDLE with done and num_out held until the next start.
REQ-026 Holding ena high SHALL yield exactly one run; a new run SHALL require ena=0 then ena=1.
REQ-027 w_addr SHALL hold its last value outside RUN states.
REQ-028 Changing input_image after the start cycle SHALL not affect the result.

Reset
REQ-029 iRst_n=0 at a clock edge SHALL force IDLE, w_addr=0, busy=0, done=0, num_out=0, and clear the accumulator, counters, argmax register and h[].
REQ-030 Reset mid-run SHALL abort the run with no done pulse; the next run SHALL be unaffected by the aborted one.

Verification
REQ-031 Reset: iRst_n=0 for 3 cycles with ena=1 -> busy=0, done=0, num_out=0, w_addr=0, state IDLE.
REQ-032 All-ones image, all L1 weights +1, L2 row 7 weights +2, other rows +1 -> done at cycle 33131, num_out=7.
REQ-033 All-zero image, any weights -> all class sums 0 (tie) -> num_out=0.
REQ-034 All-ones image, L1 weights +127 (sum 130048 saturates to 65535), L2 row 5 +1, other rows -1 -> num_out=5.
REQ-035 Pulse iRst_n low at cycle 500 of a run -> busy=0 next cycle, no done; a restarted run from REQ-032 -> num_out=7 at cycle 33131.
REQ-036 ena dropped at cycle 100 -> run completes normally; ena held high after done -> no second run, w_addr frozen.
